program_loader: RTL and testbench

Byte-stream writer for the CPU's 16 x 8 program store: it is the write side of the instruction memory that the CPU fetch path reads. A host pushes a length-prefixed, checksummed program over a valid/ready byte interface, and the block writes it into an internal 16-entry memory. The CPU reads that memory through an asynchronous read port. The block holds the CPU in reset until a complete load passes its checksum.

---
 rtl/program_loader.sv | 94 +++++++++
 tb/tb_program_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: length-prefixed, checksummed byte-stream writer for a 16 x 8 program store with an async CPU read port.
module program_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic          in_valid_i,
    input  logic [7:0]    in_data_i,
    output logic          in_ready_o,
    input  logic [AW-1:0] cpu_addr_i,
    output logic [7:0]    cpu_data_o,
    output logic          cpu_reset_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW:0]   load_count_o
);
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

    localparam logic [7:0]    MAX_LEN = 8'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d, cnt_inc;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    mem_q [DEPTH];
    logic          xfer, we;

    assign in_ready_o   = state_q inside {S_LEN, S_DATA, S_CHK};
    assign busy_o       = in_ready_o;
    assign done_o       = state_q == S_DONE;
    assign err_o        = state_q == S_ERR;
    assign cpu_reset_o  = state_q != S_DONE;
    assign load_count_o = cnt_q;
    assign cpu_data_o   = mem_q[cpu_addr_i];
    assign xfer         = in_valid_i & in_ready_o;
    assign cnt_inc      = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ptr_d   = ptr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start_i) begin
                state_d = S_LEN;
                ptr_d   = '0;
                sum_d   = '0;
                cnt_d   = '0;
            end
            S_LEN: if (xfer) begin
                state_d = (in_data_i != 8'd0 && in_data_i <= MAX_LEN) ? S_DATA : S_ERR;
                len_d   = in_data_i[AW:0];
            end
            S_DATA: if (xfer) begin
                we      = 1'b1;
                ptr_d   = ptr_q + PTR_ONE;
                sum_d   = sum_q + in_data_i;
                cnt_d   = cnt_inc;
                state_d = (cnt_inc == len_q) ? S_CHK : S_DATA;
            end
            S_CHK: if (xfer) state_d = (in_data_i == sum_q) ? S_DONE : S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            ptr_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    // Memory is never cleared; reset only suppresses a write on its own edge.
    always_ff @(posedge clk_i) begin
        if (we && !reset_i) mem_q[ptr_q] <= in_data_i;
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench; stimulus queues expected load outcomes, a negedge monitor checks them.
module tb_program_loader;
    logic       clk = 1'b0;
    logic       reset, start, in_valid, in_ready;
    logic [7:0] in_data, cpu_data;
    logic [3:0] cpu_addr;
    logic       cpu_reset, busy, done, err;
    logic [4:0] load_count;

    program_loader dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .in_valid_i(in_valid),
        .in_data_i(in_data), .in_ready_o(in_ready), .cpu_addr_i(cpu_addr),
        .cpu_data_o(cpu_data), .cpu_reset_o(cpu_reset), .busy_o(busy),
        .done_o(done), .err_o(err), .load_count_o(load_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            done, err, crst, rdy;
        logic [4:0]      cnt;
        logic [2:0]      n;
        logic [3:0][3:0] a;
        logic [3:0][7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0, bad = 0, pushed = 0, popped = 0;
    logic probe = 1'b0, mon_en = 1'b0, busy_prev = 1'b0, v_edge = 1'b0;
    logic [4:0] lc_prev = '0;

    function automatic exp_t mk(logic dn, logic er, logic cr, logic rd, logic [4:0] c);
        mk = '0;
        mk.done = dn; mk.err = er; mk.crst = cr; mk.rdy = rd; mk.cnt = c;
    endfunction

    function automatic exp_t rd(exp_t e, logic [3:0] a, logic [7:0] d);
        rd = e;
        rd.a[e.n] = a;
        rd.d[e.n] = d;
        rd.n = e.n + 3'd1;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic push(exp_t e);
        exp_q.push_back(e);
        pushed++;
    endtask

    always @(posedge clk) v_edge <= in_valid;

    always @(negedge clk) begin
        exp_t e;
        logic fire;
        fire = mon_en && (probe || (busy_prev && !busy));
        busy_prev = busy;
        if (mon_en && load_count == lc_prev + 5'd1) chk("write_needs_valid", {7'd0, v_edge}, 8'd1);
        lc_prev = load_count;
        if (fire) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_event t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("done", {7'd0, done}, {7'd0, e.done});
                chk("err", {7'd0, err}, {7'd0, e.err});
                chk("cpu_reset", {7'd0, cpu_reset}, {7'd0, e.crst});
                chk("in_ready", {7'd0, in_ready}, {7'd0, e.rdy});
                chk("busy", {7'd0, busy}, {7'd0, e.rdy});
                chk("load_count", {3'd0, load_count}, {3'd0, e.cnt});
                for (int j = 0; j < int'(e.n); j++) begin
                    cpu_addr = e.a[j];
                    #1;
                    chk($sformatf("mem[%0h]", e.a[j]), cpu_data, e.d[j]);
                end
            end
            popped++;
        end
    end

    task automatic wait_mon();
        int k = 0;
        while (popped != pushed && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (popped != pushed) begin
            total++; bad++;
            $display("FAIL monitor_timeout act=%0d exp=%0d", popped, pushed);
            popped = pushed;
        end
    endtask

    task automatic load(input logic [7:0] b[$], input bit gaps, input bit probe_start);
        start = 1'b1;
        if (!probe_start) begin in_valid = 1'b1; in_data = b[0]; end
        @(posedge clk); #1;
        start = 1'b0;
        if (probe_start) begin probe = 1'b1; @(posedge clk); #1; probe = 1'b0; end
        for (int i = 0; i < b.size(); i++) begin
            int k = 0;
            in_valid = 1'b1;
            in_data  = b[i];
            while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
            if (!in_ready) begin
                total++; bad++;
                $display("FAIL ready_timeout act=0 exp=1 byte=%0d", i);
            end
            @(posedge clk); #1;
            if (gaps && i < b.size() - 1) begin
                in_valid = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] good[$], badc[$], l16[$], part[$];
        exp_t g;
        good = '{8'h05, 8'h10, 8'h05, 8'h20, 8'h70, 8'hF0, 8'h95};
        badc = '{8'h05, 8'h10, 8'h05, 8'h20, 8'h70, 8'hF0, 8'h94};
        part = '{8'h05, 8'hAA, 8'hBB, 8'hCC};
        l16.push_back(8'h10);
        for (int i = 1; i <= 16; i++) l16.push_back(8'(i));
        l16.push_back(8'h88);
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; cpu_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;
        push(mk(0, 0, 1, 0, 0));
        probe = 1'b1; @(posedge clk); #1; probe = 1'b0;
        wait_mon();

        g = rd(rd(rd(rd(mk(1, 0, 0, 0, 5), 4'h0, 8'h10), 4'h3, 8'h70), 4'h4, 8'hF0), 4'h2, 8'h20);
        push(g);
        load(good, 0, 0);
        wait_mon();

        push(mk(0, 0, 1, 1, 0));
        push(rd(mk(1, 0, 0, 0, 5), 4'h1, 8'h05));
        load(good, 0, 1);
        wait_mon();

        push(rd(mk(0, 1, 1, 0, 5), 4'h2, 8'h20));
        load(badc, 0, 0);
        wait_mon();

        push(mk(0, 1, 1, 0, 0));
        load('{8'h00}, 0, 0);
        wait_mon();

        push(mk(0, 1, 1, 0, 0));
        load('{8'h11}, 0, 0);
        wait_mon();

        push(rd(rd(rd(mk(1, 0, 0, 0, 16), 4'hF, 8'h10), 4'h0, 8'h01), 4'h7, 8'h08));
        load(l16, 0, 0);
        wait_mon();

        push(rd(rd(rd(rd(mk(1, 0, 0, 0, 5), 4'h0, 8'h10), 4'h1, 8'h05), 4'h3, 8'h70), 4'h4, 8'hF0));
        load(good, 1, 0);
        wait_mon();

        push(rd(rd(rd(rd(mk(0, 0, 1, 0, 0), 4'h0, 8'hAA), 4'h1, 8'hBB), 4'h2, 8'hCC), 4'h3, 8'h70));
        load(part, 0, 0);
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        wait_mon();

        push(rd(rd(mk(1, 0, 0, 0, 5), 4'h0, 8'h10), 4'h5, 8'h06));
        load(good, 0, 0);
        wait_mon();

        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover_expected act=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
